demux_1x4_burst_sched: RTL and testbench

//  - Sequences a 1:4 demultiplexer datapath: distributes a single valid/ready input stream to four

---
 rtl/demux_1x4_burst_sched_pkg.sv | 30 +++
 rtl/demux_1x4_burst_sched_if.sv | 49 ++++
 rtl/demux_1x4_burst_sched_rr_pick4.sv | 39 +++
 rtl/demux_1x4_burst_sched.sv | 131 +++++++++++++
 tb/tb_demux_1x4_burst_sched.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_1x4_burst_sched_pkg.sv
// ============================================================================
//  Module      : demux_1x4_burst_sched_pkg
//  Description : Shared definitions for the 1:4 burst demux scheduler.
//                Holds the channel count, select width, the FSM state
//                encoding and a helper that sizes the beat counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_1x4_burst_sched_pkg;

    // Number of downstream channels and the width of the select that picks one.
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // Two-state scheduler: arbitrate, then stream one fixed-length burst.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // Beat counter width: max(1, clog2(burst_len)). A burst of one beat
    // still gets a 1-bit counter so the compare logic stays uniform.
    function automatic int cnt_width(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/demux_1x4_burst_sched_if.sv
// ============================================================================
//  Module      : demux_1x4_burst_sched_if
//  Description : Stream bundle between one producer, the burst scheduler and
//                four consumers.
//                  in_valid / in_data / in_ready : upstream valid/ready stream
//                  out_valid[3:0]                : one-hot per-channel valid
//                  out_data                      : shared data bus to all channels
//                  out_ready[3:0]                : per-channel consumer ready
//                Modport "slave" is the scheduler's view; modport "master" is
//                the producer/consumer side that surrounds it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface demux_1x4_burst_sched_if #(
    parameter int DATA_W = 8
);
    import demux_1x4_burst_sched_pkg::*;

    logic                in_valid;
    logic [DATA_W-1:0]   in_data;
    logic                in_ready;
    logic [NUM_CH-1:0]   out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [NUM_CH-1:0]   out_ready;

    // Scheduler side: consumes the upstream stream, drives the demux outputs.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    // Environment side: producer and the four consumers.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

endinterface

`default_nettype wire

// File: rtl/demux_1x4_burst_sched_rr_pick4.sv
// ============================================================================
//  Module      : rr_pick4
//  Description : Purely combinational rotating first-set scan over four
//                request bits. Starting at ptr and walking ptr, ptr+1, ...
//                (mod 4), returns the index of the first set bit.
//  Ports       : req[3:0]       - request / eligibility mask
//                ptr[1:0]       - scan start position
//                grant_idx[1:0] - index of the first set bit at/after ptr
//                any            - high when at least one request bit is set
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick4
    import demux_1x4_burst_sched_pkg::*;
(
    input  wire  [NUM_CH-1:0] req,
    input  wire  [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              any
);

    always_comb begin
        grant_idx = ptr;
        any       = 1'b0;
        // Walk from the farthest offset back toward ptr so that the last
        // hit written is the one closest to ptr. The index sum is SEL_W bits
        // wide, which gives the mod-4 wrap for free.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[ptr + SEL_W'(k)]) begin
                grant_idx = ptr + SEL_W'(k);
                any       = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/demux_1x4_burst_sched.sv
// ============================================================================
//  Module      : demux_1x4_burst_sched
//  Description : Burst scheduler for a 1:4 demultiplexer. Routes a single
//                valid/ready stream to four channels in fixed-length bursts,
//                rotating round-robin over the enabled channels. Drives the
//                demux select and gates per-channel valid and upstream ready.
//  Parameters  : DATA_W    - data word width
//                BURST_LEN - beats per burst before re-arbitration (1..256)
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                chan_en    - per-channel arbitration enable (sampled in IDLE)
//                bus        - stream bundle (slave modport)
//                sel        - registered demux select {S1,S0}
//                busy       - high while a burst is in progress
//                burst_done - 1-cycle pulse the cycle after a burst's last beat
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_1x4_burst_sched
    import demux_1x4_burst_sched_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
)(
    input  wire                      clk,
    input  wire                      rst,
    input  wire  [NUM_CH-1:0]        chan_en,
    demux_1x4_burst_sched_if.slave   bus,
    output logic [SEL_W-1:0]         sel,
    output logic                     busy,
    output logic                     burst_done
);

    localparam int               CNT_W  = cnt_width(BURST_LEN);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BURST_LEN - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic              r_burst_done;

    // ------------------------------------------------------------------
    // Arbitration: first enabled channel at or after the round-robin pointer
    // ------------------------------------------------------------------
    logic [SEL_W-1:0]  w_grant_idx;
    logic              w_any;

    rr_pick4 u_rr_pick4 (
        .req       (chan_en),
        .ptr       (r_rr_ptr),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

    // ------------------------------------------------------------------
    // Valid/ready gating
    // ------------------------------------------------------------------
    logic w_xfer;
    logic w_fire;
    logic w_last_beat;

    assign w_xfer      = (r_state == ST_XFER);
    assign bus.in_ready = w_xfer & bus.out_ready[r_sel];
    assign w_fire      = bus.in_valid & bus.in_ready;
    assign w_last_beat = (r_beat_cnt == C_LAST);

    // The data bus is shared by all four channels; only the one-hot valid
    // tells a consumer the word is meant for it.
    assign bus.out_data = bus.in_data;

    always_comb begin
        bus.out_valid = '0;
        if (w_xfer && bus.in_valid) begin
            bus.out_valid[r_sel] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Scheduler FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            r_rr_ptr     <= '0;
            r_beat_cnt   <= '0;
            r_burst_done <= 1'b0;
        end else begin
            r_burst_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // chan_en only matters here; once a burst starts it is
                    // committed to r_sel until its last beat.
                    if (bus.in_valid && w_any) begin
                        r_sel      <= w_grant_idx;
                        r_beat_cnt <= '0;
                        r_state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_fire) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_last_beat) begin
                            // Pointer moves past the channel just served even
                            // if it is the only enabled one; the scan wraps
                            // back to it.
                            r_rr_ptr     <= r_sel + 1'b1;
                            r_burst_done <= 1'b1;
                            r_state      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel        = r_sel;
    assign busy       = w_xfer;
    assign burst_done = r_burst_done;

endmodule

`default_nettype wire

// File: tb/tb_demux_1x4_burst_sched.sv
// ============================================================================
//  Module      : tb_demux_1x4_burst_sched
//  Description : Directed, scoreboard-based bench for demux_1x4_burst_sched.
//                dut_a uses BURST_LEN=4, dut_b uses BURST_LEN=1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_1x4_burst_sched;
    import demux_1x4_burst_sched_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux_1x4_burst_sched_if #(.DATA_W(8)) bus_a ();
    demux_1x4_burst_sched_if #(.DATA_W(8)) bus_b ();

    logic [NUM_CH-1:0] chan_en_a, chan_en_b;
    logic [SEL_W-1:0]  sel_a, sel_b;
    logic              busy_a, busy_b, bd_a, bd_b;

    demux_1x4_burst_sched #(.DATA_W(8), .BURST_LEN(4)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .chan_en    (chan_en_a),
        .bus        (bus_a),
        .sel        (sel_a),
        .busy       (busy_a),
        .burst_done (bd_a)
    );

    demux_1x4_burst_sched #(.DATA_W(8), .BURST_LEN(1)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .chan_en    (chan_en_b),
        .bus        (bus_b),
        .sel        (sel_b),
        .busy       (busy_b),
        .burst_done (bd_b)
    );

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int         n_tests = 0;
    int         n_fail  = 0;
    int         xfer_a, xfer_b, bdcnt_a, bdcnt_b, busycnt_a;
    logic [3:0] seen_a;
    logic       ready_seen_a;
    logic [7:0] next_a, next_b;      // next word the producer offers
    logic [7:0] exp_data_a, exp_data_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input int ch, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.ch = 2'(ch); e.data = exp_data_a; qa.push_back(e);
            exp_data_a++;
        end
    endtask

    task automatic push_b(input int ch);
        exp_t e;
        e.ch = 2'(ch); e.data = exp_data_b; qb.push_back(e);
        exp_data_b++;
    endtask

    task automatic clear_stats();
        xfer_a = 0; xfer_b = 0; bdcnt_a = 0; bdcnt_b = 0; busycnt_a = 0;
        seen_a = '0; ready_seen_a = 1'b0;
    endtask

    // One clock: called at a falling edge with inputs already set; samples
    // just after the falling edge, then returns at the next falling edge.
    task automatic step();
        exp_t       e;
        logic [3:0] oh;
        bus_a.in_data = next_a;
        bus_b.in_data = next_b;
        #1;
        if (!rst && bus_a.in_valid && bus_a.in_ready) begin
            check("a_xfer_expected", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
                e  = qa.pop_front();
                oh = 4'b0001 << e.ch;
                check("a_beat_channel", bus_a.out_valid, oh);
                check("a_beat_data", bus_a.out_data, e.data);
            end
            xfer_a++; next_a++;
        end
        if (!rst && bus_b.in_valid && bus_b.in_ready) begin
            check("b_xfer_expected", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
                e  = qb.pop_front();
                oh = 4'b0001 << e.ch;
                check("b_beat_channel", bus_b.out_valid, oh);
                check("b_beat_data", bus_b.out_data, e.data);
            end
            xfer_b++; next_b++;
        end
        if (bd_a)   bdcnt_a++;
        if (bd_b)   bdcnt_b++;
        if (busy_a) busycnt_a++;
        seen_a = seen_a | bus_a.out_valid;
        if (bus_a.in_ready) ready_seen_a = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        chan_en_a = '0; chan_en_b = '0;
        bus_a.in_valid = 1'b0; bus_a.out_ready = 4'hF;
        bus_b.in_valid = 1'b0; bus_b.out_ready = 4'hF;
        next_a = '0; next_b = '0; exp_data_a = '0; exp_data_b = '0;
        clear_stats();
        @(negedge clk);
        step();
        step();

        // Reset state
        check("rst_out_valid", bus_a.out_valid, 32'h0);
        check("rst_in_ready", bus_a.in_ready, 32'h0);
        check("rst_busy", busy_a, 32'h0);
        check("rst_sel", sel_a, 32'h0);
        check("rst_burst_done", bd_a, 32'h0);
        check("rst_b_sel", sel_b, 32'h0);
        rst = 1'b0;

        // Basic rotation: 20 beats, 0-3 ch0, 4-7 ch1, 8-11 ch2, 12-15 ch3, 16-19 ch0
        clear_stats();
        chan_en_a = 4'hF;
        for (int k = 0; k < 20; k++) push_a((k / 4) % 4, 1);
        bus_a.in_valid = 1'b1;
        repeat (25) step();
        check("rot_xfers", xfer_a, 32'd20);
        check("rot_burst_done", bdcnt_a, 32'd4);
        check("rot_busy_cycles", busycnt_a, 32'd20);
        bus_a.in_valid = 1'b0;
        step();
        check("rot_queue_empty", qa.size(), 32'd0);

        // Masking and wrap: chan_en=1010 -> 1,3,1,3
        do_reset();
        clear_stats();
        chan_en_a = 4'b1010;
        push_a(1, 4); push_a(3, 4); push_a(1, 4); push_a(3, 4);
        bus_a.in_valid = 1'b1;
        repeat (20) step();
        bus_a.in_valid = 1'b0;
        step();
        check("mask_queue_empty", qa.size(), 32'd0);
        check("mask_ch02_quiet", seen_a & 4'b0101, 32'h0);
        check("mask_xfers", xfer_a, 32'd16);

        // No channel enabled: nothing accepted, stays IDLE
        do_reset();
        clear_stats();
        chan_en_a = 4'b0000;
        bus_a.in_valid = 1'b1;
        repeat (20) step();
        check("zero_ready_seen", ready_seen_a, 32'd0);
        check("zero_busy", busycnt_a, 32'd0);
        bus_a.in_valid = 1'b0;

        // Back-pressure on ch0 after its 2nd beat
        do_reset();
        clear_stats();
        chan_en_a = 4'hF;
        push_a(0, 4);
        bus_a.in_valid = 1'b1;
        repeat (3) step();
        bus_a.out_ready = 4'b1110;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_in_ready", bus_a.in_ready, 32'd0);
            check("bp_out_valid", bus_a.out_valid, 32'h1);
            check("bp_beat_cnt", dut_a.r_beat_cnt, 32'd2);
        end
        bus_a.out_ready = 4'hF;
        repeat (2) step();
        bus_a.in_valid = 1'b0;
        step();
        check("bp_queue_empty", qa.size(), 32'd0);
        check("bp_xfers", xfer_a, 32'd4);
        check("bp_burst_done", bdcnt_a, 32'd1);

        // Mid-burst mask change: drop ch1 after its first beat
        do_reset();
        clear_stats();
        chan_en_a = 4'hF;
        push_a(0, 4); push_a(1, 4); push_a(2, 4);
        bus_a.in_valid = 1'b1;
        repeat (7) step();
        chan_en_a = 4'b1101;
        repeat (8) step();
        bus_a.in_valid = 1'b0;
        step();
        check("mmask_queue_empty", qa.size(), 32'd0);
        check("mmask_xfers", xfer_a, 32'd12);

        // Reset during beat 2 of a ch2 burst
        do_reset();
        clear_stats();
        chan_en_a = 4'hF;
        push_a(0, 4); push_a(1, 4); push_a(2, 2);
        bus_a.in_valid = 1'b1;
        repeat (13) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_out_valid", bus_a.out_valid, 32'h0);
        check("mrst_sel", sel_a, 32'h0);
        check("mrst_burst_done", bd_a, 32'h0);
        check("mrst_busy", busy_a, 32'h0);
        check("mrst_queue_drained", qa.size(), 32'd0);
        push_a(0, 4);
        repeat (5) step();
        bus_a.in_valid = 1'b0;
        step();
        check("mrst_queue_empty", qa.size(), 32'd0);

        // BURST_LEN=1: one beat per channel, rotating, every other cycle
        do_reset();
        clear_stats();
        chan_en_b = 4'hF;
        for (int k = 0; k < 8; k++) push_b(k % 4);
        bus_b.in_valid = 1'b1;
        repeat (16) step();
        check("bl1_xfers", xfer_b, 32'd8);
        check("bl1_burst_done", bdcnt_b, 32'd7);
        bus_b.in_valid = 1'b0;
        step();
        check("bl1_queue_empty", qb.size(), 32'd0);
        check("bl1_burst_done_final", bdcnt_b, 32'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
